mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'hbfc0_0000, reset value of out_pc.
REQ-002 SHALL have ports clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have ports in_valid (input, 1) and in_ready (output, 1): execute-to-memory handshake; transfer when both high.
REQ-005 SHALL have inputs in_op (6, opcode), in_rm (1, load), in_wm (1, store), in_addr (32, effective address), in_wdata (32, store data), in_regw (5, destination register), in_pc (32).
REQ-006 SHALL have data-bus outputs dreq_valid (1), dreq_addr (32), dreq_size (3: 0=byte, 1=half, 2=word), dreq_strobe (4), dreq_data (32).
REQ-007 SHALL have data-bus inputs dresp_addr_ok (1), dresp_data_ok (1), dresp_data (32).
REQ-008 SHALL have outputs out_valid (1), out_data (32), out_regw (5), out_pc (32), stall (1, busy with a memory access).

Function
REQ-009 SHALL implement FSM IDLE, REQ, WAIT; in_ready=1 only in IDLE; stall=1 in REQ and WAIT.
REQ-010 IDLE, accepted with in_rm=in_wm=0: SHALL register out_data=in_addr, out_regw, out_pc, and pulse out_valid for exactly one cycle on the next cycle (latency 1); state stays IDLE.
REQ-011 IDLE, accepted with in_rm or in_wm: SHALL latch all inputs and go to REQ; dreq_valid SHALL be 1 from the next cycle.
REQ-012 REQ: dreq_valid and all dreq_* SHALL be held stable until dresp_addr_ok=1; then go to WAIT, or directly to IDLE with completion if dresp_data_ok=1 in the same cycle.
REQ-013 WAIT: dreq_valid=0; on dresp_data_ok=1 SHALL complete: out_valid=1 for one cycle on the next cycle, state IDLE.
REQ-014 dreq_addr SHALL equal the latched address unmodified; dreq_size from opcode: LB/LBU/SB=0 (6'h20/24/28), LH/LHU/SH=1 (6'h21/25/29), LW/SW=2 (6'h23/2b).
REQ-015 Stores: dreq_strobe SHALL be 4'b0001<<addr[1:0] (byte), 4'b0011<<addr[1:0] (half), 4'b1111 (word); dreq_data SHALL be wdata byte/half replicated to all lanes; loads: strobe=0.
REQ-016 Loads: lane SHALL be selected by latched addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through; result registered to out_data.
REQ-017 Stores: completion SHALL pulse out_valid with out_regw=0 and out_data=0.
REQ-018 Unknown opcode with in_rm/in_wm set SHALL be treated as word access.
REQ-019 dresp_* asserted in IDLE SHALL be ignored.
REQ-020 out_data, out_regw, out_pc SHALL hold their values between out_valid pulses.

Reset
REQ-021 reset=1 at a clock edge SHALL force state IDLE, dreq_valid=0, dreq_addr=0, dreq_size=0, dreq_strobe=0, dreq_data=0, out_valid=0, out_data=0, out_regw=0, out_pc=PC_RESET, stall=0, in_ready=0 during reset.
REQ-022 Reset asserted mid-transaction (REQ or WAIT) SHALL abandon it with no out_valid; a late dresp_data_ok after reset SHALL be ignored.

Configuration
REQ-023 With MEM_ALIGN_CHECK_EN defined: an access with half at addr[0]=1 or word at addr[1:0]!=0 SHALL issue no bus request, complete in one cycle with out_valid=1, out_regw=0, and assert output misalign (1) with that pulse; without it, no misalign port exists and the address is issued as-is.

Verification
REQ-024 ADDU-style pass-through in_addr=32'h1234, regw=5 -> next cycle out_valid=1, out_data=32'h1234, out_regw=5; stall never 1.
REQ-025 LB addr=32'h1000_0003, addr_ok after 2 cycles, data_ok 3 cycles later with data=32'h80xx_xxxx -> dreq_size=0, stable over the wait; out_data=32'hffff_ff80, one out_valid pulse.
REQ-026 SH addr=32'h2002, wdata=32'h0000_beef, addr_ok and data_ok same cycle -> strobe=4'b1100, dreq_data=32'hbeef_beef, direct return to IDLE, out_regw=0.
REQ-027 LHU addr=32'h4, data=32'h8001_7fff -> out_data=32'h0000_7fff; LH addr=32'h6 same data -> out_data=32'hffff_8001.
REQ-028 Reset in WAIT, then data_ok=1 -> no out_valid, state IDLE, in_ready=1 after reset release.
REQ-029 MEM_ALIGN_CHECK_EN defined, LW addr=32'h1001 -> dreq_valid stays 0, misalign=1 with out_valid one cycle later.

Source files
------------

// File: rtl/mem_access.sv
// ============================================================================
// Module   : mem_access
// Purpose  : Memory-stage bridge between the execute stage and a valid/addr_ok/
//            data_ok data bus. Optional MEM_ALIGN_CHECK_EN adds misalign trap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access #(
  parameter logic [31:0] PC_RESET = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic        in_rm,
  input  logic        in_wm,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_regw,
  input  logic [31:0] in_pc,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [4:0]  out_regw,
  output logic [31:0] out_pc,
  output logic        stall
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic        is_load_q, is_load_d;
  logic [4:0]  regw_q, regw_d;
  logic [31:0] pc_q, pc_d;
  logic        dreq_valid_q, dreq_valid_d;
  logic [2:0]  dreq_size_q, dreq_size_d;
  logic [3:0]  dreq_strobe_q, dreq_strobe_d;
  logic [31:0] dreq_data_q, dreq_data_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [4:0]  out_regw_q, out_regw_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [2:0]  w_size;
  logic        w_misal;
  logic        w_done;

  // Access size: unknown opcodes fall into the word case.
  function automatic logic [2:0] size_of(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: size_of = 3'd0;
      6'h21, 6'h25, 6'h29: size_of = 3'd1;
      default:             size_of = 3'd2;
    endcase
  endfunction

  function automatic logic [3:0] strobe_of(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'd0:    strobe_of = 4'b0001 << a;
      3'd1:    strobe_of = 4'b0011 << a;
      default: strobe_of = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lanes_of(input logic [2:0] size, input logic [31:0] wd);
    case (size)
      3'd0:    lanes_of = {4{wd[7:0]}};
      3'd1:    lanes_of = {2{wd[15:0]}};
      default: lanes_of = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_of(input logic [5:0] op, input logic [1:0] a,
                                          input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (op)
      6'h20:   load_of = {{24{b[7]}}, b};
      6'h24:   load_of = {24'd0, b};
      6'h21:   load_of = {{16{h[15]}}, h};
      6'h25:   load_of = {16'd0, h};
      default: load_of = d;
    endcase
  endfunction

  assign w_size = size_of(in_op);

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign w_misal = ((w_size == 3'd1) && in_addr[0]) ||
                   ((w_size == 3'd2) && (in_addr[1:0] != 2'b00));
  assign misalign = misalign_q;
`else
  assign w_misal = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    is_load_d     = is_load_q;
    regw_d        = regw_q;
    pc_d          = pc_q;
    dreq_valid_d  = 1'b0;
    dreq_size_d   = dreq_size_q;
    dreq_strobe_d = dreq_strobe_q;
    dreq_data_d   = dreq_data_q;
    out_valid_d   = 1'b0;
    out_data_d    = out_data_q;
    out_regw_d    = out_regw_q;
    out_pc_d      = out_pc_q;
    w_done        = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misalign_d    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (!(in_rm || in_wm)) begin
            out_valid_d = 1'b1;
            out_data_d  = in_addr;
            out_regw_d  = in_regw;
            out_pc_d    = in_pc;
          end else if (w_misal) begin
            out_valid_d = 1'b1;
            out_data_d  = 32'd0;
            out_regw_d  = 5'd0;
            out_pc_d    = in_pc;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_d  = 1'b1;
`endif
          end else begin
            op_d          = in_op;
            addr_d        = in_addr;
            is_load_d     = in_rm;
            regw_d        = in_regw;
            pc_d          = in_pc;
            dreq_valid_d  = 1'b1;
            dreq_size_d   = w_size;
            dreq_strobe_d = in_rm ? 4'b0000 : strobe_of(w_size, in_addr[1:0]);
            dreq_data_d   = lanes_of(w_size, in_wdata);
            state_d       = S_REQ;
          end
        end
      end
      S_REQ: begin
        dreq_valid_d = 1'b1;
        if (dresp_addr_ok) begin
          dreq_valid_d = 1'b0;
          if (dresp_data_ok) begin
            w_done  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dresp_data_ok) begin
          w_done  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stores report no writeback: zero register and zero data.
    if (w_done) begin
      out_valid_d = 1'b1;
      out_pc_d    = pc_q;
      out_data_d  = is_load_q ? load_of(op_q, addr_q[1:0], dresp_data) : 32'd0;
      out_regw_d  = is_load_q ? regw_q : 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_q          <= 6'd0;
      addr_q        <= 32'd0;
      is_load_q     <= 1'b0;
      regw_q        <= 5'd0;
      pc_q          <= 32'd0;
      dreq_valid_q  <= 1'b0;
      dreq_size_q   <= 3'd0;
      dreq_strobe_q <= 4'd0;
      dreq_data_q   <= 32'd0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 32'd0;
      out_regw_q    <= 5'd0;
      out_pc_q      <= PC_RESET;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      is_load_q     <= is_load_d;
      regw_q        <= regw_d;
      pc_q          <= pc_d;
      dreq_valid_q  <= dreq_valid_d;
      dreq_size_q   <= dreq_size_d;
      dreq_strobe_q <= dreq_strobe_d;
      dreq_data_q   <= dreq_data_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_regw_q    <= out_regw_d;
      out_pc_q      <= out_pc_d;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

  assign in_ready    = (state_q == S_IDLE) && !reset;
  assign stall       = (state_q != S_IDLE);
  assign dreq_valid  = dreq_valid_q;
  assign dreq_addr   = addr_q;
  assign dreq_size   = dreq_size_q;
  assign dreq_strobe = dreq_strobe_q;
  assign dreq_data   = dreq_data_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_regw    = out_regw_q;
  assign out_pc      = out_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// Module   : tb_mem_access
// Purpose  : Randomized self-checking bench for mem_access against a
//            byte-lane reference model; MEM_ALIGN_CHECK_EN adds misalign case.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access;

  localparam logic [31:0] PC_RST = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [5:0]  in_op;
  logic        in_rm, in_wm;
  logic [31:0] in_addr, in_wdata, in_pc;
  logic [4:0]  in_regw;
  logic        dreq_valid;
  logic [31:0] dreq_addr, dreq_data;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [31:0] dresp_data;
  logic        out_valid, stall;
  logic [31:0] out_data, out_pc;
  logic [4:0]  out_regw;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access #(.PC_RESET(PC_RST)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rm(in_rm), .in_wm(in_wm),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_regw(in_regw), .in_pc(in_pc),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_data(out_data), .out_regw(out_regw), .out_pc(out_pc),
    .stall(stall)
`ifdef MEM_ALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_bytes(input logic [5:0] op);
    if (op == 6'h20 || op == 6'h24 || op == 6'h28) return 1;
    if (op == 6'h21 || op == 6'h25 || op == 6'h29) return 2;
    return 4;
  endfunction

  // Shift the addressed lane down, mask to width, extend for signed loads.
  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr,
                                           input logic [31:0] data);
    int          nb;
    logic [31:0] v, mask;
    nb = ref_bytes(op);
    if (nb == 4) return data;
    v    = data >> (addr[1:0] * 8);
    mask = (nb == 1) ? 32'h0000_00ff : 32'h0000_ffff;
    v    = v & mask;
    if ((op == 6'h20 || op == 6'h21) && v > (mask >> 1)) v = v | ~mask;
    return v;
  endfunction

  task automatic issue(input logic [5:0] op, input logic rm, input logic wm,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] regw, input logic [31:0] pc);
    check_eq("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1; in_op = op; in_rm = rm; in_wm = wm;
    in_addr = addr; in_wdata = wdata; in_regw = regw; in_pc = pc;
    step();
    in_valid = 1'b0; in_rm = 1'b0; in_wm = 1'b0;
    in_addr = $urandom; in_wdata = $urandom; in_regw = 5'($urandom);
  endtask

  task automatic run_alu(input logic [31:0] addr, input logic [4:0] regw, input logic [31:0] pc);
    issue(6'h00, 1'b0, 1'b0, addr, 32'h0, regw, pc);
    check_eq("alu_valid", out_valid, 1'b1);
    check_eq("alu_data", out_data, addr);
    check_eq("alu_regw", out_regw, regw);
    check_eq("alu_pc", out_pc, pc);
    check_eq("alu_stall", stall, 1'b0);
    check_eq("alu_dreq", dreq_valid, 1'b0);
    step();
    check_eq("alu_pulse_end", out_valid, 1'b0);
    check_eq("alu_hold", out_data, addr);
    check_eq("alu_stall2", stall, 1'b0);
  endtask

  task automatic run_mem(input logic [5:0] op, input logic rm, input logic wm,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] regw, input logic [31:0] pc,
                         input int ad, input int dd, input logic [31:0] rdata);
    int          nb;
    logic [2:0]  esz;
    logic [3:0]  estb;
    logic [31:0] edat, eout;
    logic [4:0]  ereg;
    nb   = ref_bytes(op);
    esz  = (nb == 1) ? 3'd0 : (nb == 2) ? 3'd1 : 3'd2;
    estb = 4'd0;
    if (!rm) for (int i = 0; i < nb; i++) estb = estb | (4'd1 << (int'(addr[1:0]) + i));
    edat = (nb == 4) ? wdata :
           (nb == 2) ? {16'd0, wdata[15:0]} * 32'h0001_0001 :
                       {24'd0, wdata[7:0]} * 32'h0101_0101;
    eout = rm ? ref_load(op, addr, rdata) : 32'd0;
    ereg = rm ? regw : 5'd0;
    issue(op, rm, wm, addr, wdata, regw, pc);
    for (int c = 0; c <= ad; c++) begin
      check_eq("req_valid", dreq_valid, 1'b1);
      check_eq("req_addr", dreq_addr, addr);
      check_eq("req_size", dreq_size, esz);
      check_eq("req_strobe", dreq_strobe, estb);
      if (!rm) check_eq("req_data", dreq_data, edat);
      check_eq("req_stall", stall, 1'b1);
      check_eq("req_in_ready", in_ready, 1'b0);
      check_eq("req_out_valid", out_valid, 1'b0);
      dresp_data = $urandom;
      if (c == ad) begin
        dresp_addr_ok = 1'b1;
        dresp_data_ok = (dd == 0);
        if (dd == 0) dresp_data = rdata;
      end
      step();
      dresp_addr_ok = 1'b0;
      dresp_data_ok = 1'b0;
    end
    for (int c = 1; c <= dd; c++) begin
      check_eq("wait_dreq", dreq_valid, 1'b0);
      check_eq("wait_stall", stall, 1'b1);
      check_eq("wait_out_valid", out_valid, 1'b0);
      dresp_data = $urandom;
      if (c == dd) begin
        dresp_data_ok = 1'b1;
        dresp_data    = rdata;
      end
      step();
      dresp_data_ok = 1'b0;
    end
    check_eq("done_valid", out_valid, 1'b1);
    check_eq("done_data", out_data, eout);
    check_eq("done_regw", out_regw, ereg);
    check_eq("done_pc", out_pc, pc);
    check_eq("done_stall", stall, 1'b0);
    check_eq("done_in_ready", in_ready, 1'b1);
    check_eq("done_dreq", dreq_valid, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    check_eq("done_misalign", misalign, 1'b0);
`endif
    step();
    check_eq("done_pulse_end", out_valid, 1'b0);
    check_eq("done_hold", out_data, eout);
  endtask

  initial begin
    logic [5:0] ops [8];
    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b};
    reset = 1'b1; in_valid = 1'b0; in_op = 6'd0; in_rm = 1'b0; in_wm = 1'b0;
    in_addr = 32'd0; in_wdata = 32'd0; in_regw = 5'd0; in_pc = 32'd0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'd0;

    step();
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_dreq_valid", dreq_valid, 1'b0);
    check_eq("rst_dreq_addr", dreq_addr, 32'd0);
    check_eq("rst_dreq_size", dreq_size, 3'd0);
    check_eq("rst_dreq_strobe", dreq_strobe, 4'd0);
    check_eq("rst_dreq_data", dreq_data, 32'd0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_out_regw", out_regw, 5'd0);
    check_eq("rst_out_pc", out_pc, PC_RST);
    check_eq("rst_stall", stall, 1'b0);
    reset = 1'b0;
    step();
    check_eq("post_rst_ready", in_ready, 1'b1);

    // Bus responses while idle must not trigger anything.
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'hdead_beef;
    step();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    check_eq("idle_resp_valid", out_valid, 1'b0);
    check_eq("idle_resp_dreq", dreq_valid, 1'b0);
    check_eq("idle_resp_stall", stall, 1'b0);

    run_alu(32'h0000_1234, 5'd5, 32'h0040_0000);
    run_mem(6'h20, 1'b1, 1'b0, 32'h1000_0003, 32'h0, 5'd7, 32'h0040_0004, 2, 3, 32'h8012_3456);
    check_eq("lb_signext", out_data, 32'hffff_ff80);
    run_mem(6'h29, 1'b0, 1'b1, 32'h0000_2002, 32'h0000_beef, 5'd9, 32'h0040_0008, 0, 0, 32'h0);
    run_mem(6'h25, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 5'd3, 32'h0040_000c, 1, 1, 32'h8001_7fff);
    check_eq("lhu_val", out_data, 32'h0000_7fff);
    run_mem(6'h21, 1'b1, 1'b0, 32'h0000_0006, 32'h0, 5'd4, 32'h0040_0010, 0, 2, 32'h8001_7fff);
    check_eq("lh_val", out_data, 32'hffff_8001);

    // Reset while waiting for data abandons the access; late data_ok is ignored.
    issue(6'h23, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd6, 32'h0040_0014);
    dresp_addr_ok = 1'b1;
    step();
    dresp_addr_ok = 1'b0;
    check_eq("rw_in_wait", stall, 1'b1);
    reset = 1'b1;
    step();
    check_eq("rw_rst_valid", out_valid, 1'b0);
    check_eq("rw_rst_ready", in_ready, 1'b0);
    check_eq("rw_rst_stall", stall, 1'b0);
    check_eq("rw_rst_pc", out_pc, PC_RST);
    reset = 1'b0; dresp_data_ok = 1'b1; dresp_data = 32'h1111_2222;
    step();
    dresp_data_ok = 1'b0;
    check_eq("rw_late_valid", out_valid, 1'b0);
    check_eq("rw_late_ready", in_ready, 1'b1);
    check_eq("rw_late_stall", stall, 1'b0);
    step();
    check_eq("rw_late_valid2", out_valid, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
    issue(6'h23, 1'b1, 1'b0, 32'h0000_1001, 32'h0, 5'd8, 32'h0040_0018);
    check_eq("mis_dreq", dreq_valid, 1'b0);
    check_eq("mis_valid", out_valid, 1'b1);
    check_eq("mis_flag", misalign, 1'b1);
    check_eq("mis_regw", out_regw, 5'd0);
    check_eq("mis_stall", stall, 1'b0);
    step();
    check_eq("mis_flag_end", misalign, 1'b0);
    check_eq("mis_dreq2", dreq_valid, 1'b0);
`endif

    for (int n = 0; n < 200; n++) begin
      int          kind, nb;
      logic [5:0]  op;
      logic        rm;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      a    = $urandom;
      if (kind == 0) begin
        run_alu(a, 5'($urandom), $urandom);
      end else begin
        if (kind == 9) begin
          op = 6'h30 + 6'($urandom_range(0, 15));
          rm = 1'($urandom_range(0, 1));
        end else begin
          op = ops[kind - 1];
          rm = (op < 6'h28);
        end
        nb = ref_bytes(op);
        a  = a & ~(32'(nb) - 32'd1);
        run_mem(op, rm, !rm, a, $urandom, 5'($urandom), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
